dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data memory of the RISCV_R core between two requesters.
  - Port 0: the core load/store unit.
  - Port 1: the loader/debug port, which preloads data and inspects results between program runs.
- Uses round-robin arbitration, a lock for loader bursts, and misalignment checking.
- Returns read data with fixed one-cycle latency, and drives a stall signal back to the core pipeline.

---
 rtl/dmem_arbiter_if.sv | 61 ++++++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports, the core stall line and the memory port
// of the data-memory arbiter. The master side is the outside world (core LSU,
// loader and the RAM model); the slave side is the arbiter itself.
interface dmem_arbiter_if #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int DEPTH_LOG2 = 8
);
    // Port 0: core load/store unit
    logic                  p0_req;
    logic                  p0_we;
    logic [AW-1:0]         p0_addr;
    logic [DW-1:0]         p0_wdata;
    logic [DW/8-1:0]       p0_be;
    logic                  p0_gnt;
    logic                  p0_rvalid;
    logic [DW-1:0]         p0_rdata;
    logic                  p0_err;

    // Port 1: loader / debug
    logic                  p1_req;
    logic                  p1_we;
    logic [AW-1:0]         p1_addr;
    logic [DW-1:0]         p1_wdata;
    logic [DW/8-1:0]       p1_be;
    logic                  p1_gnt;
    logic                  p1_rvalid;
    logic [DW-1:0]         p1_rdata;
    logic                  p1_err;
    logic                  p1_lock;

    logic                  core_stall;

    // Single-port synchronous data memory
    logic                  mem_en;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic [DW/8-1:0]       mem_be;
    logic [DW-1:0]         mem_rdata;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_be,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_be, p1_lock,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  core_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_be,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_be, p1_lock,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output core_stall,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: round-robin
// between core (port 0) and loader (port 1), loader burst lock, misalignment
// detection, one-cycle fixed-latency responses and a core stall output.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int NP = 2;
    localparam int BW = DW / 8;
    localparam logic [BW-1:0] BE_ALL = {BW{1'b1}};
    localparam logic [BW-1:0] BE_LO  = BE_ALL >> (BW / 2);
    localparam logic [BW-1:0] BE_HI  = ~BE_LO;

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    // Requester fields gathered into arrays so both ports share one datapath.
    // Only the address bits that reach memory (plus the byte offset) matter.
    logic [NP-1:0]         req;
    logic [NP-1:0]         we;
    logic [NP-1:0]         mis;
    logic [DEPTH_LOG2+1:0] addr  [NP];
    logic [DW-1:0]         wdata [NP];
    logic [BW-1:0]         be    [NP];

    assign req      = {bus.p1_req, bus.p0_req};
    assign we       = {bus.p1_we,  bus.p0_we};
    assign addr[0]  = bus.p0_addr[DEPTH_LOG2+1:0];
    assign addr[1]  = bus.p1_addr[DEPTH_LOG2+1:0];
    assign wdata[0] = bus.p0_wdata;
    assign wdata[1] = bus.p1_wdata;
    assign be[0]    = bus.p0_be;
    assign be[1]    = bus.p1_be;

    // Word access must be word aligned, half-word access must be even.
    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_align
            assign mis[gi] = ((be[gi] == BE_ALL) && (addr[gi][1:0] != 2'b00)) ||
                             (((be[gi] == BE_LO) || (be[gi] == BE_HI)) && addr[gi][0]);
        end
    endgenerate

    state_t        state_q, state_d;
    logic          rr_q, rr_d;          // 0: core preferred on contention
    logic [NP-1:0] rvalid_q, rvalid_d;
    logic [NP-1:0] err_q, err_d;
    logic [NP-1:0] rd_q, rd_d;          // response carries memory read data

    logic [NP-1:0] gnt;
    logic          sel;
    logic          issue;

    // Combinational grant: lock gives port 1 exclusive use, otherwise
    // a lone requester wins and contention is resolved by rr_q.
    always_comb begin
        gnt = '0;
        if (!reset) begin
            if (state_q == LOCK1) begin
                gnt = {req[1], 1'b0};
            end else if (req == 2'b11) begin
                gnt = rr_q ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    assign sel   = gnt[1];
    assign issue = (|gnt) && !mis[sel];

    // Next-state: FSM transitions, round-robin pointer and response capture.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        rvalid_d = gnt;
        err_d    = gnt & mis;
        rd_d     = gnt & ~we & ~mis;
        case (state_q)
            ARB: begin
                if (req == 2'b11) begin
                    rr_d = gnt[0];
                end
                if (gnt[1] && bus.p1_lock) begin
                    state_d = LOCK1;
                end
            end
            LOCK1: begin
                if (!bus.p1_lock) begin
                    state_d = ARB;
                    rr_d    = 1'b0;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Arbiter state and registered response flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB;
            rr_q     <= 1'b0;
            rvalid_q <= '0;
            err_q    <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rd_q     <= rd_d;
        end
    end

    assign bus.p0_gnt     = gnt[0];
    assign bus.p1_gnt     = gnt[1];
    assign bus.core_stall = req[0] && !gnt[0];

    assign bus.p0_rvalid  = rvalid_q[0];
    assign bus.p1_rvalid  = rvalid_q[1];
    assign bus.p0_err     = err_q[0];
    assign bus.p1_err     = err_q[1];
    assign bus.p0_rdata   = rd_q[0] ? bus.mem_rdata : '0;
    assign bus.p1_rdata   = rd_q[1] ? bus.mem_rdata : '0;

    // Memory buses are held at zero whenever no access is issued.
    assign bus.mem_en     = issue;
    assign bus.mem_we     = issue && we[sel];
    assign bus.mem_addr   = issue ? addr[sel][DEPTH_LOG2+1:2] : '0;
    assign bus.mem_wdata  = issue ? wdata[sel] : '0;
    assign bus.mem_be     = issue ? be[sel] : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a RAM model serves the memory port, a
// per-cycle reference model predicts every output, and directed literal
// checks pin the reference model to hand-computed values.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();
    dmem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;
    int cycle = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // RAM attached to the DUT memory port (registered read, byte writes)
    logic [31:0] bench_mem [256];
    logic [31:0] ref_mem   [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            bench_mem[i] = 32'hA500_0000 | i;
            ref_mem[i]   = 32'hA500_0000 | i;
        end
        bench_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]   = 32'hDEAD_BEEF;
    end

    initial bus.mem_rdata = '0;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) bench_mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= bench_mem[bus.mem_addr];
            end
        end
    end

    // Reference model state
    bit          m_locked   = 0;
    bit          m_prefer1  = 0;
    bit          pend_v   [2];
    bit          pend_err [2];
    logic [31:0] pend_data[2];
    bit          q_req [2];
    bit          q_we  [2];
    logic [31:0] q_addr[2];
    logic [31:0] q_wd  [2];
    logic [3:0]  q_be  [2];

    function automatic bit misaligned(input logic [3:0] b, input logic [31:0] a);
        if (b == 4'hF) return a[1:0] != 2'b00;
        if (b == 4'h3 || b == 4'hC) return a[0];
        return 1'b0;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            pend_v[i] = 0; pend_err[i] = 0; pend_data[i] = '0;
        end
    end

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin : cmp
        int  w;
        bit  mis_w;
        bit  en_w;
        int  idx;
        q_req[0] = bus.p0_req; q_we[0] = bus.p0_we; q_addr[0] = bus.p0_addr;
        q_wd[0]  = bus.p0_wdata; q_be[0] = bus.p0_be;
        q_req[1] = bus.p1_req; q_we[1] = bus.p1_we; q_addr[1] = bus.p1_addr;
        q_wd[1]  = bus.p1_wdata; q_be[1] = bus.p1_be;
        if (reset) begin
            m_locked = 0; m_prefer1 = 0;
            for (int i = 0; i < 2; i++) begin
                pend_v[i] = 0; pend_err[i] = 0; pend_data[i] = '0;
            end
        end
        // who wins this cycle
        if (reset)                          w = -1;
        else if (m_locked)                  w = q_req[1] ? 1 : -1;
        else if (q_req[0] && q_req[1])      w = m_prefer1 ? 1 : 0;
        else if (q_req[0])                  w = 0;
        else if (q_req[1])                  w = 1;
        else                                w = -1;
        mis_w = (w >= 0) ? misaligned(q_be[w], q_addr[w]) : 1'b0;
        en_w  = (w >= 0) && !mis_w;

        chk("p0_gnt", bus.p0_gnt, w == 0);
        chk("p1_gnt", bus.p1_gnt, w == 1);
        chk("core_stall", bus.core_stall, q_req[0] && (w != 0));
        chk("mem_en", bus.mem_en, en_w);
        chk("mem_we", bus.mem_we, en_w && q_we[w]);
        if (en_w) begin
            chk("mem_addr", bus.mem_addr, q_addr[w][9:2]);
            chk("mem_be", bus.mem_be, q_be[w]);
            if (q_we[w]) chk("mem_wdata", bus.mem_wdata, q_wd[w]);
        end
        chk("p0_rvalid", bus.p0_rvalid, pend_v[0]);
        chk("p0_err", bus.p0_err, pend_err[0]);
        chk("p0_rdata", bus.p0_rdata, pend_data[0]);
        chk("p1_rvalid", bus.p1_rvalid, pend_v[1]);
        chk("p1_err", bus.p1_err, pend_err[1]);
        chk("p1_rdata", bus.p1_rdata, pend_data[1]);

        for (int i = 0; i < 2; i++) begin
            pend_v[i] = 0; pend_err[i] = 0; pend_data[i] = '0;
        end
        if (w >= 0) begin
            idx = int'(q_addr[w][9:2]);
            $display("cycle %0d: port%0d %s addr=0x%08h be=%b%s", cycle, w,
                     q_we[w] ? "write" : "read ", q_addr[w], q_be[w], mis_w ? " misaligned" : "");
            pend_v[w]   = 1;
            pend_err[w] = mis_w;
            if (!mis_w && !q_we[w]) pend_data[w] = ref_mem[idx];
            if (!mis_w && q_we[w])
                for (int b = 0; b < 4; b++)
                    if (q_be[w][b]) ref_mem[idx][8*b +: 8] = q_wd[w][8*b +: 8];
        end
        if (!reset) begin
            if (m_locked) begin
                if (!bus.p1_lock) begin m_locked = 0; m_prefer1 = 0; end
            end else begin
                if (q_req[0] && q_req[1]) m_prefer1 = (w == 0);
                if (w == 1 && bus.p1_lock) m_locked = 1;
            end
        end
        cycle++;
    end

    // Outputs captured at the negedge of each directed cycle
    logic        c_gnt0, c_gnt1, c_stall, c_en, c_we, c_rv0, c_rv1, c_err0, c_err1;
    logic [7:0]  c_addr;
    logic [3:0]  c_be;
    logic [31:0] c_rd0, c_rd1;

    task automatic cyc(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic [3:0] b0, input bit r1, input bit w1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic [3:0] b1, input bit lk);
        bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0; bus.p0_be = b0;
        bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1; bus.p1_be = b1;
        bus.p1_lock = lk;
        @(negedge clk);
        c_gnt0 = bus.p0_gnt; c_gnt1 = bus.p1_gnt; c_stall = bus.core_stall;
        c_en = bus.mem_en; c_we = bus.mem_we; c_addr = bus.mem_addr; c_be = bus.mem_be;
        c_rv0 = bus.p0_rvalid; c_rv1 = bus.p1_rvalid; c_err0 = bus.p0_err; c_err1 = bus.p1_err;
        c_rd0 = bus.p0_rdata; c_rd1 = bus.p1_rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit lk);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, lk);
    endtask

    initial begin : stim
        logic [3:0] gseq, sseq;
        int cnt, stl;
        // reset state
        reset = 1'b1;
        idle(0);
        chk("reset_p0_gnt", c_gnt0, 0);
        chk("reset_p0_rvalid", c_rv0, 0);
        chk("reset_mem_en", c_en, 0);
        reset = 1'b0;

        // core read of 0x10
        cyc(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        chk("t1_gnt", c_gnt0, 1);
        chk("t1_mem_addr", c_addr, 8'd4);
        chk("t1_stall", c_stall, 0);
        idle(0);
        chk("t1_rvalid", c_rv0, 1);
        chk("t1_rdata", c_rd0, 32'hDEAD_BEEF);

        // contention from reset alternates
        reset = 1'b1; idle(0); reset = 1'b0;
        gseq = '0; sseq = '0;
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 32'h10, 0, 4'hF, 1, 0, 32'h14, 0, 4'hF, 0);
            gseq = {gseq[2:0], c_gnt0};
            sseq = {sseq[2:0], c_stall};
        end
        chk("t2_gnt_seq", gseq, 4'b1010);
        chk("t2_stall_seq", sseq, 4'b0101);

        // one contention cycle so the loader is preferred next
        cyc(1, 0, 32'h10, 0, 4'hF, 1, 0, 32'h14, 0, 4'hF, 0);
        chk("t3_pre_gnt0", c_gnt0, 1);

        // locked loader burst
        cnt = 0; stl = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 32'h10, 0, 4'hF, 1, 1, 32'h20, 32'h1122_3344, 4'hF, 1);
            cnt += int'(c_gnt1);
            stl += int'(c_stall);
        end
        chk("t3_p1_grants", cnt, 3);
        chk("t3_p0_stalls", stl, 3);
        cyc(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        chk("t3_held_gnt0", c_gnt0, 0);
        chk("t3_held_stall", c_stall, 1);
        cyc(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        chk("t3_after_gnt0", c_gnt0, 1);
        idle(0);

        // misaligned word store
        cyc(1, 1, 32'h22, 32'h5555_5555, 4'hF, 0, 0, 0, 0, 0, 0);
        chk("t4_gnt", c_gnt0, 1);
        chk("t4_mem_en", c_en, 0);
        idle(0);
        chk("t4_rvalid", c_rv0, 1);
        chk("t4_err", c_err0, 1);
        chk("t4_rdata", c_rd0, 0);
        chk("t4_mem_word", bench_mem[8], 32'h1122_3344);

        // loader byte write then word read
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h21, 32'h0000_AB00, 4'b0010, 0);
        chk("t5_mem_we", c_we, 1);
        chk("t5_mem_be", c_be, 4'b0010);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h20, 0, 4'hF, 0);
        idle(0);
        chk("t5_rvalid", c_rv1, 1);
        chk("t5_rdata", c_rd1, 32'h1122_AB44);

        // half-word alignment
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h21, 0, 4'b0011, 0);
        idle(0);
        chk("t5_half_odd_err", c_err1, 1);
        cyc(1, 0, 32'h22, 0, 4'b1100, 0, 0, 0, 0, 0, 0);
        idle(0);
        chk("t5_half_even_err", c_err0, 0);
        chk("t5_half_even_rdata", c_rd0, 32'h1122_AB44);

        // lock without loader request is ignored
        cnt = 0;
        for (int k = 0; k < 2; k++) begin
            cyc(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0, 1);
            cnt += int'(c_gnt0);
        end
        chk("t6_lock_noreq", cnt, 2);

        // reset drops a pending response and resets the pointer
        cyc(1, 0, 32'h10, 0, 4'hF, 1, 0, 32'h14, 0, 4'hF, 0);
        cyc(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        chk("t6_gnt", c_gnt0, 1);
        reset = 1'b1;
        idle(0);
        chk("t6_no_rvalid", c_rv0, 0);
        reset = 1'b0;
        cyc(1, 0, 32'h10, 0, 4'hF, 1, 0, 32'h14, 0, 4'hF, 0);
        chk("t6_rr_after_reset", c_gnt0, 1);
        idle(0);

        // reset releases the lock
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h30, 32'h0BAD_F00D, 4'hF, 1);
        chk("t7_lock_gnt1", c_gnt1, 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        cyc(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        chk("t7_p0_after_reset", c_gnt0, 1);
        idle(0);
        idle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
